decoder3_wb: RTL and testbench



---
 rtl/decoder3_wb.sv | 246 ++++++++++++++++++++++++
 tb/tb_decoder3_wb.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decoder3_wb.sv
// -----------------------------------------------------------------------------
// decoder3_wb
//
// Wishbone address decoder and router for one master and three slaves.
// Each transaction's address is decoded once, in IDLE. The selected slave
// index is latched in tgt. While ACTIVE, cycle, strobe, ack and read data
// pass straight between the master and that slave. Unmapped addresses, and
// accesses that wait too long for an ack, end with a one-cycle error, so the
// master can never hang.
//
// Ports
//   clk                  clock; all state updates on the rising edge
//   rst                  asynchronous, active-low reset
//   wbm_*                master-facing Wishbone port (adr/dat/we/sel/stb/cyc
//                        in; dat/ack/err out)
//   wbsK_adr_o/dat_o/    master fields broadcast to every slave (K = 0..2)
//   we_o/sel_o
//   wbsK_cyc_o/stb_o     cycle/strobe, gated to the selected slave only
//   wbsK_dat_i/ack_i     slave read data and acknowledge
//   dbg_state            current FSM state (0 IDLE, 1 ACTIVE, 2 ERR)
//
// Handshake: a slave transfer completes in a cycle where its cyc, stb and
// ack are all high. The master sees that ack in the same cycle,
// combinationally. wbm_ack_o and wbm_err_o are never high together. If the
// master drops cyc, the transaction is abandoned at once and any ack in that
// cycle is ignored.
// -----------------------------------------------------------------------------
module decoder3_wb #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    ADDR_WIDTH     = 32,
  parameter int                    SELECT_WIDTH   = DATA_WIDTH / 8,
  parameter logic [ADDR_WIDTH-1:0] S0_BASE        = ADDR_WIDTH'(32'h0000_0000),
  parameter logic [ADDR_WIDTH-1:0] S0_MASK        = ADDR_WIDTH'(32'hFFFF_0000),
  parameter logic [ADDR_WIDTH-1:0] S1_BASE        = ADDR_WIDTH'(32'h1000_0000),
  parameter logic [ADDR_WIDTH-1:0] S1_MASK        = ADDR_WIDTH'(32'hF000_0000),
  parameter logic [ADDR_WIDTH-1:0] S2_BASE        = ADDR_WIDTH'(32'h2000_0000),
  parameter logic [ADDR_WIDTH-1:0] S2_MASK        = ADDR_WIDTH'(32'hF000_0000),
  parameter int                    TIMEOUT_CYCLES = 255
) (
  input  logic                    clk,
  input  logic                    rst,

  // master port
  input  logic [ADDR_WIDTH-1:0]   wbm_adr_i,
  input  logic [DATA_WIDTH-1:0]   wbm_dat_i,
  output logic [DATA_WIDTH-1:0]   wbm_dat_o,
  input  logic                    wbm_we_i,
  input  logic [SELECT_WIDTH-1:0] wbm_sel_i,
  input  logic                    wbm_stb_i,
  input  logic                    wbm_cyc_i,
  output logic                    wbm_ack_o,
  output logic                    wbm_err_o,

  // slave 0
  output logic [ADDR_WIDTH-1:0]   wbs0_adr_o,
  output logic [DATA_WIDTH-1:0]   wbs0_dat_o,
  input  logic [DATA_WIDTH-1:0]   wbs0_dat_i,
  output logic                    wbs0_we_o,
  output logic [SELECT_WIDTH-1:0] wbs0_sel_o,
  output logic                    wbs0_stb_o,
  output logic                    wbs0_cyc_o,
  input  logic                    wbs0_ack_i,

  // slave 1
  output logic [ADDR_WIDTH-1:0]   wbs1_adr_o,
  output logic [DATA_WIDTH-1:0]   wbs1_dat_o,
  input  logic [DATA_WIDTH-1:0]   wbs1_dat_i,
  output logic                    wbs1_we_o,
  output logic [SELECT_WIDTH-1:0] wbs1_sel_o,
  output logic                    wbs1_stb_o,
  output logic                    wbs1_cyc_o,
  input  logic                    wbs1_ack_i,

  // slave 2
  output logic [ADDR_WIDTH-1:0]   wbs2_adr_o,
  output logic [DATA_WIDTH-1:0]   wbs2_dat_o,
  input  logic [DATA_WIDTH-1:0]   wbs2_dat_i,
  output logic                    wbs2_we_o,
  output logic [SELECT_WIDTH-1:0] wbs2_sel_o,
  output logic                    wbs2_stb_o,
  output logic                    wbs2_cyc_o,
  input  logic                    wbs2_ack_i,

  // debug
  output logic [1:0]              dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_ERR    = 2'd2
  } state_t;

  // The counter keeps at least one bit so the design still elaborates when
  // the timeout is disabled. In that case the counter value is never used.
  localparam int TCNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TCNT_W-1:0] TCNT_LAST =
    (TIMEOUT_CYCLES > 0) ? TCNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);

  state_t            state, state_next;
  logic [1:0]        tgt, tgt_next;
  logic [TCNT_W-1:0] tcnt, tcnt_next;

  // ---------------------------------------------------------------------------
  // Address decode (used only in IDLE); the lowest index wins on overlap
  // ---------------------------------------------------------------------------
  logic       hit0, hit1, hit2, hit_any;
  logic [1:0] dec_tgt;

  always_comb begin
    hit0    = ((wbm_adr_i & S0_MASK) == S0_BASE);
    hit1    = ((wbm_adr_i & S1_MASK) == S1_BASE);
    hit2    = ((wbm_adr_i & S2_MASK) == S2_BASE);
    hit_any = hit0 | hit1 | hit2;
    dec_tgt = 2'd0;
    if (hit0)      dec_tgt = 2'd0;
    else if (hit1) dec_tgt = 2'd1;
    else if (hit2) dec_tgt = 2'd2;
  end

  // ---------------------------------------------------------------------------
  // Response mux from the latched target
  // ---------------------------------------------------------------------------
  logic                  tgt_ack;
  logic [DATA_WIDTH-1:0] tgt_dat;

  always_comb begin
    tgt_ack = 1'b0;
    tgt_dat = '0;
    case (tgt)
      2'd0: begin tgt_ack = wbs0_ack_i; tgt_dat = wbs0_dat_i; end
      2'd1: begin tgt_ack = wbs1_ack_i; tgt_dat = wbs1_dat_i; end
      2'd2: begin tgt_ack = wbs2_ack_i; tgt_dat = wbs2_dat_i; end
      default: begin tgt_ack = 1'b0; tgt_dat = '0; end
    endcase
  end

  logic timeout_hit;
  assign timeout_hit = TIMEOUT_EN && (tcnt == TCNT_LAST);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      tgt   <= 2'd0;
      tcnt  <= '0;
    end else begin
      state <= state_next;
      tgt   <= tgt_next;
      tcnt  <= tcnt_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    tgt_next   = tgt;
    tcnt_next  = tcnt;
    case (state)
      ST_IDLE: begin
        if (wbm_cyc_i && wbm_stb_i) begin
          if (hit_any) begin
            tgt_next   = dec_tgt;
            tcnt_next  = '0;
            state_next = ST_ACTIVE;
          end else begin
            state_next = ST_ERR;
          end
        end
      end
      ST_ACTIVE: begin
        // Priority order: a master abort beats a completing ack, and a
        // completing ack beats the timeout.
        if (!wbm_cyc_i) begin
          state_next = ST_IDLE;
        end else if (tgt_ack) begin
          state_next = ST_IDLE;
        end else if (timeout_hit) begin
          state_next = ST_ERR;
        end else begin
          tcnt_next = tcnt + 1'b1;
        end
      end
      ST_ERR: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs. All control outputs come from state, so an asynchronous reset
  // clears them at once.
  // ---------------------------------------------------------------------------
  logic active;
  assign active = (state == ST_ACTIVE);

  always_comb begin
    wbs0_cyc_o = 1'b0;
    wbs0_stb_o = 1'b0;
    wbs1_cyc_o = 1'b0;
    wbs1_stb_o = 1'b0;
    wbs2_cyc_o = 1'b0;
    wbs2_stb_o = 1'b0;
    if (active) begin
      case (tgt)
        2'd0: begin wbs0_cyc_o = wbm_cyc_i; wbs0_stb_o = wbm_stb_i; end
        2'd1: begin wbs1_cyc_o = wbm_cyc_i; wbs1_stb_o = wbm_stb_i; end
        2'd2: begin wbs2_cyc_o = wbm_cyc_i; wbs2_stb_o = wbm_stb_i; end
        default: ;
      endcase
    end
  end

  // The ack is gated by cyc so that an ack arriving in an abort cycle never
  // reaches the master.
  assign wbm_ack_o = active && wbm_cyc_i && tgt_ack;
  assign wbm_err_o = (state == ST_ERR) && wbm_cyc_i;
  assign wbm_dat_o = active ? tgt_dat : '0;

  // Master request fields go to every slave; only cyc/stb are gated.
  assign wbs0_adr_o = wbm_adr_i;
  assign wbs0_dat_o = wbm_dat_i;
  assign wbs0_we_o  = wbm_we_i;
  assign wbs0_sel_o = wbm_sel_i;

  assign wbs1_adr_o = wbm_adr_i;
  assign wbs1_dat_o = wbm_dat_i;
  assign wbs1_we_o  = wbm_we_i;
  assign wbs1_sel_o = wbm_sel_i;

  assign wbs2_adr_o = wbm_adr_i;
  assign wbs2_dat_o = wbm_dat_i;
  assign wbs2_we_o  = wbm_we_i;
  assign wbs2_sel_o = wbm_sel_i;

  assign dbg_state = state;

endmodule

// File: tb/tb_decoder3_wb.sv
// -----------------------------------------------------------------------------
// tb_decoder3_wb
//
// Directed bench for decoder3_wb with the timeout set to 16 cycles.
// Inputs change on the falling clock edge and direct checks run 1 ns later.
// A response monitor runs 2 ns after the falling edge. Whenever it sees a
// master ack, it takes the next entry from the expected-data queue and
// compares it with wbm_dat_o.
// -----------------------------------------------------------------------------
module tb_decoder3_wb;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = 4;
  localparam int TO = 16;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACTIVE = 2'd1;
  localparam logic [1:0] S_ERR    = 2'd2;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] wbm_adr_i = '0;
  logic [DW-1:0] wbm_dat_i = '0;
  logic [DW-1:0] wbm_dat_o;
  logic          wbm_we_i = 1'b0;
  logic [SW-1:0] wbm_sel_i = '0;
  logic          wbm_stb_i = 1'b0;
  logic          wbm_cyc_i = 1'b0;
  logic          wbm_ack_o, wbm_err_o;

  logic [AW-1:0] wbs0_adr_o, wbs1_adr_o, wbs2_adr_o;
  logic [DW-1:0] wbs0_dat_o, wbs1_dat_o, wbs2_dat_o;
  logic [DW-1:0] wbs0_dat_i = '0, wbs1_dat_i = '0, wbs2_dat_i = '0;
  logic          wbs0_we_o, wbs1_we_o, wbs2_we_o;
  logic [SW-1:0] wbs0_sel_o, wbs1_sel_o, wbs2_sel_o;
  logic          wbs0_stb_o, wbs1_stb_o, wbs2_stb_o;
  logic          wbs0_cyc_o, wbs1_cyc_o, wbs2_cyc_o;
  logic          wbs0_ack_i = 1'b0, wbs1_ack_i = 1'b0, wbs2_ack_i = 1'b0;
  logic [1:0]    dbg_state;

  decoder3_wb #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .wbm_adr_i  (wbm_adr_i),
    .wbm_dat_i  (wbm_dat_i),
    .wbm_dat_o  (wbm_dat_o),
    .wbm_we_i   (wbm_we_i),
    .wbm_sel_i  (wbm_sel_i),
    .wbm_stb_i  (wbm_stb_i),
    .wbm_cyc_i  (wbm_cyc_i),
    .wbm_ack_o  (wbm_ack_o),
    .wbm_err_o  (wbm_err_o),
    .wbs0_adr_o (wbs0_adr_o),
    .wbs0_dat_o (wbs0_dat_o),
    .wbs0_dat_i (wbs0_dat_i),
    .wbs0_we_o  (wbs0_we_o),
    .wbs0_sel_o (wbs0_sel_o),
    .wbs0_stb_o (wbs0_stb_o),
    .wbs0_cyc_o (wbs0_cyc_o),
    .wbs0_ack_i (wbs0_ack_i),
    .wbs1_adr_o (wbs1_adr_o),
    .wbs1_dat_o (wbs1_dat_o),
    .wbs1_dat_i (wbs1_dat_i),
    .wbs1_we_o  (wbs1_we_o),
    .wbs1_sel_o (wbs1_sel_o),
    .wbs1_stb_o (wbs1_stb_o),
    .wbs1_cyc_o (wbs1_cyc_o),
    .wbs1_ack_i (wbs1_ack_i),
    .wbs2_adr_o (wbs2_adr_o),
    .wbs2_dat_o (wbs2_dat_o),
    .wbs2_dat_i (wbs2_dat_i),
    .wbs2_we_o  (wbs2_we_o),
    .wbs2_sel_o (wbs2_sel_o),
    .wbs2_stb_o (wbs2_stb_o),
    .wbs2_cyc_o (wbs2_cyc_o),
    .wbs2_ack_i (wbs2_ack_i),
    .dbg_state  (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard state and checking helpers
  // ---------------------------------------------------------------------------
  int tests  = 0;
  int failed = 0;
  logic [DW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Every slave cyc/stb plus the master ack and err, packed together. Used
  // where all of them must be low.
  function automatic logic [7:0] ctl_vec();
    return {wbs0_cyc_o, wbs0_stb_o, wbs1_cyc_o, wbs1_stb_o,
            wbs2_cyc_o, wbs2_stb_o, wbm_ack_o, wbm_err_o};
  endfunction

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic drive_master(input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                              input logic we, input logic [SW-1:0] sel, input logic on);
    wbm_adr_i = adr;
    wbm_dat_i = dat;
    wbm_we_i  = we;
    wbm_sel_i = sel;
    wbm_cyc_i = on;
    wbm_stb_i = on;
  endtask

  task automatic master_idle();
    wbm_cyc_i = 1'b0;
    wbm_stb_i = 1'b0;
    wbm_we_i  = 1'b0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Response monitor: each master ack consumes one expected data word
  // ---------------------------------------------------------------------------
  always begin
    @(negedge clk);
    #2;
    if (rst === 1'b1 && wbm_ack_o === 1'b1) begin
      check("ack_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) check("ack_data", wbm_dat_o, exp_q.pop_front());
    end
  end

  // ---------------------------------------------------------------------------
  // Directed stimulus
  // ---------------------------------------------------------------------------
  initial begin
    // reset
    repeat (2) next_cycle();
    #1;
    check("reset_ctl", ctl_vec(), 8'h00);
    check("reset_dat", wbm_dat_o, 32'h0);
    check("reset_state", dbg_state, S_IDLE);
    next_cycle();
    rst = 1'b1;

    // Read slave 1, which acks in its first strobed cycle
    next_cycle();
    drive_master(32'h1000_0040, 32'h0, 1'b0, 4'hF, 1'b1);
    wbs1_dat_i = 32'hDEAD_BEEF;
    #1;
    check("rd1_decode_no_stb", wbs1_stb_o, 1'b0);
    next_cycle();
    wbs1_ack_i = 1'b1;
    exp_q.push_back(32'hDEAD_BEEF);
    #1;
    check("rd1_state_active", dbg_state, S_ACTIVE);
    check("rd1_stb1", {wbs0_stb_o, wbs1_stb_o, wbs2_stb_o}, 3'b010);
    check("rd1_ack", wbm_ack_o, 1'b1);
    check("rd1_dat", wbm_dat_o, 32'hDEAD_BEEF);
    next_cycle();
    master_idle();
    wbs1_ack_i = 1'b0;
    #1;
    check("rd1_idle_after", dbg_state, S_IDLE);
    check("rd1_quiet", ctl_vec(), 8'h00);

    // Write slave 2 with 3 wait states
    next_cycle();
    drive_master(32'h2000_0004, 32'h1234_5678, 1'b1, 4'hF, 1'b1);
    wbs2_dat_i = 32'h0;
    exp_q.push_back(32'h0);
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      wbs2_ack_i = (i == 3);
      #1;
      check("wr2_stb", {wbs0_stb_o, wbs1_stb_o, wbs2_stb_o}, 3'b001);
      check("wr2_fields", {wbs2_adr_o, wbs2_dat_o}, {32'h2000_0004, 32'h1234_5678});
      check("wr2_we_sel", {wbs2_we_o, wbs2_sel_o}, 5'b1_1111);
      check("wr2_ack", wbm_ack_o, 1'(i == 3));
    end
    next_cycle();
    master_idle();
    wbs2_ack_i = 1'b0;
    #1;
    check("wr2_idle_after", dbg_state, S_IDLE);
    check("wr2_quiet", ctl_vec(), 8'h00);

    // Unmapped address
    next_cycle();
    drive_master(32'h3000_0000, 32'h0, 1'b0, 4'hF, 1'b1);
    #1;
    check("unm_no_err_yet", wbm_err_o, 1'b0);
    next_cycle();
    #1;
    check("unm_err", ctl_vec(), 8'h01);
    check("unm_state", dbg_state, S_ERR);
    next_cycle();
    master_idle();
    #1;
    check("unm_err_one_cycle", ctl_vec(), 8'h00);
    check("unm_idle", dbg_state, S_IDLE);

    // Timeout: slave 0 never acks
    next_cycle();
    drive_master(32'h0000_0100, 32'h0, 1'b0, 4'hF, 1'b1);
    for (int i = 0; i < TO; i++) begin
      next_cycle();
      #1;
      check("to_cyc0_held", {wbs0_cyc_o, wbs0_stb_o, wbm_err_o}, 3'b110);
    end
    next_cycle();
    #1;
    check("to_err_cycle", ctl_vec(), 8'h01);
    next_cycle();
    master_idle();
    #1;
    check("to_idle", dbg_state, S_IDLE);
    // A following access to slave 1 completes normally
    next_cycle();
    drive_master(32'h1000_0000, 32'h0, 1'b0, 4'hF, 1'b1);
    wbs1_dat_i = 32'hCAFE_F00D;
    next_cycle();
    wbs1_ack_i = 1'b1;
    exp_q.push_back(32'hCAFE_F00D);
    #1;
    check("to_next_ack", {wbs1_cyc_o, wbm_ack_o, wbm_err_o}, 3'b110);
    next_cycle();
    master_idle();
    wbs1_ack_i = 1'b0;

    // Abort: the master drops cyc in ACTIVE while a late ack arrives
    next_cycle();
    drive_master(32'h2000_0000, 32'h0, 1'b0, 4'hF, 1'b1);
    next_cycle();
    master_idle();
    wbs2_ack_i = 1'b1;
    #1;
    check("abort_no_ack", {wbs2_cyc_o, wbm_ack_o}, 2'b00);
    next_cycle();
    wbs2_ack_i = 1'b0;
    #1;
    check("abort_idle", dbg_state, S_IDLE);

    // Reset asserted mid-transaction
    next_cycle();
    drive_master(32'h1000_0000, 32'h0, 1'b0, 4'hF, 1'b1);
    next_cycle();
    #1;
    check("rst_mid_active", wbs1_stb_o, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("rst_async_ctl", ctl_vec(), 8'h00);
    check("rst_async_state", dbg_state, S_IDLE);
    next_cycle();
    master_idle();
    rst = 1'b1;
    // After release, 0x10 is routed to slave 0
    next_cycle();
    drive_master(32'h0000_0010, 32'h0, 1'b0, 4'hF, 1'b1);
    wbs0_dat_i = 32'h0000_5A5A;
    next_cycle();
    wbs0_ack_i = 1'b1;
    exp_q.push_back(32'h0000_5A5A);
    #1;
    check("post_rst_route0", {wbs0_stb_o, wbs1_stb_o, wbs2_stb_o, wbm_ack_o}, 4'b1001);
    next_cycle();
    master_idle();
    wbs0_ack_i = 1'b0;

    // Back-to-back: slave 0 then slave 1 with stb held continuously
    next_cycle();
    drive_master(32'h0000_0020, 32'h0, 1'b0, 4'hF, 1'b1);
    wbs0_dat_i = 32'h0000_AAAA;
    wbs1_dat_i = 32'h1111_BBBB;
    next_cycle();
    wbs0_ack_i = 1'b1;
    exp_q.push_back(32'h0000_AAAA);
    #1;
    check("b2b_first_ack", {wbs0_stb_o, wbm_ack_o}, 2'b11);
    next_cycle();
    wbs0_ack_i = 1'b0;
    wbm_adr_i  = 32'h1000_0008;
    #1;
    check("b2b_bubble_state", dbg_state, S_IDLE);
    check("b2b_bubble_quiet", ctl_vec(), 8'h00);
    next_cycle();
    wbs1_ack_i = 1'b1;
    exp_q.push_back(32'h1111_BBBB);
    #1;
    check("b2b_second_state", dbg_state, S_ACTIVE);
    check("b2b_second_ack", {wbs0_stb_o, wbs1_stb_o, wbm_ack_o}, 3'b011);
    next_cycle();
    master_idle();
    wbs1_ack_i = 1'b0;

    // Every expected response must have been consumed
    repeat (2) next_cycle();
    #3;
    check("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
